// File: rtl/bubble_sort_pkg.sv
// Shared definitions for the bubble sort sequencer: controller state
// encoding and the default batch geometry.
package bubble_sort_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/bubble_cmp_swap.sv
// Combinational compare-swap cell: orders one pair of unsigned words.
// Equal words are passed straight through and never flagged as a swap.
module bubble_cmp_swap #(
    parameter int WIDTH = bubble_sort_pkg::DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             swap
);

    // Strict greater-than keeps equal pairs in place.
    always_comb begin
        swap = (a > b);
        lo   = swap ? b : a;
        hi   = swap ? a : b;
    end

endmodule

// File: rtl/bubble_sort_ctrl.sv
// Bubble sort sequencer: loads DEPTH words over a valid/ready input,
// sorts them with one compare-swap per cycle, then streams them out
// smallest first over a valid/ready output with a last marker.
// Optional feature: define SORT_EARLY_EXIT_EN to leave SORT as soon as a
// full pass completes without any swap.
module bubble_sort_ctrl
    import bubble_sort_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_IDX  = PW'(DEPTH - 1);
    localparam logic [PW-1:0] LAST_PASS = PW'(DEPTH - 2);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    pass;
    logic [PW-1:0]    j;
    logic [PW-1:0]    j_nxt;
    logic [PW-1:0]    j_lim;

    logic             in_fire;
    logic             out_fire;
    logic             load_done;
    logic             pass_end;
    logic             sort_done;
    logic             drain_done;

    logic [WIDTH-1:0] cmp_lo;
    logic [WIDTH-1:0] cmp_hi;
    logic             cmp_swap;

    assign j_nxt = j + PW'(1);
    // Each pass bubbles one more word into its final slot, so the
    // last compared index shrinks by one per pass.
    assign j_lim = LAST_PASS - pass;

    bubble_cmp_swap #(.WIDTH(WIDTH)) u_cmp (
        .a    (mem[j]),
        .b    (mem[j_nxt]),
        .lo   (cmp_lo),
        .hi   (cmp_hi),
        .swap (cmp_swap)
    );

    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign load_done  = in_fire && (wr_ptr == LAST_IDX);
    assign pass_end   = (j == j_lim);
    assign drain_done = out_fire && out_last;

`ifdef SORT_EARLY_EXIT_EN
    logic swapped;

    // The current compare counts too: a swap on the final pair of a
    // pass must keep the sort running.
    assign sort_done = (state == SORT) && pass_end &&
                       ((pass == LAST_PASS) || !(swapped || cmp_swap));

    // Tracks whether the pass in progress has swapped anything yet.
    always_ff @(posedge clk) begin
        if (rst) begin
            swapped <= 1'b0;
        end else if (state == SORT && !pass_end) begin
            swapped <= swapped | cmp_swap;
        end else begin
            swapped <= 1'b0;
        end
    end
`else
    assign sort_done = (state == SORT) && pass_end && (pass == LAST_PASS);
`endif

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for every flop so all registers
        // update from the same pre-edge values regardless of block order.
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default first so no path through the case leaves the
        // output unassigned, which would infer a latch.
        next_state = state;
        unique case (state)
            LOAD:    if (load_done)  next_state = SORT;
            SORT:    if (sort_done)  next_state = DRAIN;
            DRAIN:   if (drain_done) next_state = LOAD;
            default: next_state = LOAD;
        endcase
    end

    // Output decode; out_data is forced to zero outside DRAIN.
    always_comb begin
        in_ready  = (state == LOAD);
        busy      = (state == SORT);
        out_valid = (state == DRAIN);
        out_data  = out_valid ? mem[rd_ptr] : '0;
        out_last  = out_valid && (rd_ptr == LAST_IDX);
    end

    // Word storage, pointers and sort counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            pass   <= '0;
            j      <= '0;
            // NOTE: the array is cleared on reset because out_data and a
            // discarded batch must never expose stale words; with only
            // DEPTH entries this is a handful of flops, not a RAM.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    pass <= '0;
                    j    <= '0;
                    if (in_fire) begin
                        mem[wr_ptr] <= in_data;
                        wr_ptr      <= load_done ? '0 : wr_ptr + PW'(1);
                    end
                end
                SORT: begin
                    mem[j]     <= cmp_lo;
                    mem[j_nxt] <= cmp_hi;
                    if (pass_end) begin
                        j    <= '0;
                        pass <= sort_done ? '0 : pass + PW'(1);
                    end else begin
                        j <= j_nxt;
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        rd_ptr <= out_last ? '0 : rd_ptr + PW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Directed bench for bubble_sort_ctrl: a table of batches with hand-sorted
// results, SORT lengths and swap counts, plus a mid-SORT reset sequence.
`timescale 1ns/1ps
module tb_bubble_sort_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0][3:0] din;
        logic [3:0][3:0] dout;
        int              cyc_full;
        int              cyc_early;
        int              swaps;
        int              stall;
        bit              hold;
    } vec_t;

    vec_t vecs [8];

    bubble_sort_ctrl #(.WIDTH(4), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int a, b, c, d, input int sa, sb, sc, sd,
                                input int full, early, sw, stall, input bit hold);
        vec_t v;
        v.din[0] = 4'(a);  v.din[1] = 4'(b);  v.din[2] = 4'(c);  v.din[3] = 4'(d);
        v.dout[0] = 4'(sa); v.dout[1] = 4'(sb); v.dout[2] = 4'(sc); v.dout[3] = 4'(sd);
        v.cyc_full = full;
        v.cyc_early = early;
        v.swaps = sw;
        v.stall = stall;
        v.hold = hold;
        return v;
    endfunction

    // Presents the four words one per cycle; ends on the negedge after the last accept.
    task automatic load_words(input string tag, input vec_t v);
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = v.din[k];
            check($sformatf("%s in_ready load%0d", tag, k), 32'(in_ready), 32'd1);
            @(negedge clk);
        end
        in_valid = v.hold;
        in_data  = 4'hF;
    endtask

    // Counts SORT cycles and swaps, then drains and checks order and out_last.
    task automatic sort_and_drain(input string tag, input vec_t v);
        int n = 0;
        int sw = 0;
        int t;
        int exp_cyc;
`ifdef SORT_EARLY_EXIT_EN
        exp_cyc = v.cyc_early;
`else
        exp_cyc = v.cyc_full;
`endif
        while (busy && n < 64) begin
            if (dut.cmp_swap) sw++;
            if (in_ready) check($sformatf("%s in_ready in SORT", tag), 32'(in_ready), 32'd0);
            n++;
            @(negedge clk);
        end
        check($sformatf("%s sort cycles", tag), 32'(n), 32'(exp_cyc));
        check($sformatf("%s swap count", tag), 32'(sw), 32'(v.swaps));

        for (int i = 0; i < 4; i++) begin
            t = 0;
            while (!out_valid && t < 16) begin
                t++;
                @(negedge clk);
            end
            check($sformatf("%s out_valid word%0d", tag, i), 32'(out_valid), 32'd1);
            check($sformatf("%s in_ready in DRAIN", tag), 32'(in_ready), 32'd0);
            if (i == 0) begin
                out_ready = 1'b0;
                for (int s = 0; s < v.stall; s++) begin
                    check($sformatf("%s stall%0d data", tag, s), 32'(out_data), 32'(v.dout[0]));
                    @(negedge clk);
                end
            end
            out_ready = 1'b1;
            check($sformatf("%s data word%0d", tag, i), 32'(out_data), 32'(v.dout[i]));
            check($sformatf("%s last word%0d", tag, i), 32'(out_last), (i == 3) ? 32'd1 : 32'd0);
            if (i == 3) in_valid = 1'b0;
            @(negedge clk);
        end
        out_ready = 1'b0;
        check($sformatf("%s in_ready after drain", tag), 32'(in_ready), 32'd1);
        check($sformatf("%s out_valid after drain", tag), 32'(out_valid), 32'd0);
        check($sformatf("%s busy after drain", tag), 32'(busy), 32'd0);
    endtask

    initial begin
        int n;

        //           inputs         sorted         full early swaps stall hold
        vecs[0] = mk(10, 5, 14, 6,  5, 6, 10, 14,  6, 6, 3, 0, 1'b0);
        vecs[1] = mk( 3, 3,  1, 3,  1, 3,  3,  3,  6, 6, 2, 0, 1'b0);
        vecs[2] = mk(10, 5, 14, 6,  5, 6, 10, 14,  6, 6, 3, 5, 1'b0);
        vecs[3] = mk( 1, 2,  3, 4,  1, 2,  3,  4,  6, 3, 0, 0, 1'b0);
        vecs[4] = mk( 4, 3,  2, 1,  1, 2,  3,  4,  6, 6, 6, 0, 1'b0);
        vecs[5] = mk( 7, 7,  7, 7,  7, 7,  7,  7,  6, 3, 0, 0, 1'b0);
        vecs[6] = mk( 8, 7,  9, 0,  0, 7,  8,  9,  6, 6, 4, 0, 1'b1);
        vecs[7] = mk( 2, 9,  0, 5,  0, 2,  5,  9,  6, 6, 3, 0, 1'b1);

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("reset in_ready",  32'(in_ready),  32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_last",  32'(out_last),  32'd0);
        check("reset out_data",  32'(out_data),  32'd0);
        check("reset busy",      32'(busy),      32'd0);

        for (int v = 0; v < 8; v++) begin
            load_words($sformatf("v%0d", v), vecs[v]);
            sort_and_drain($sformatf("v%0d", v), vecs[v]);
        end

        // Reset in the third SORT cycle discards the batch.
        load_words("rst", vecs[6]);
        n = 0;
        while (n < 3 && busy) begin
            n++;
            if (n < 3) @(negedge clk);
        end
        check("rst reached sort cycle 3", 32'(n), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst in_ready",  32'(in_ready),  32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst busy",      32'(busy),      32'd0);
        check("rst out_data",  32'(out_data),  32'd0);
        load_words("post_rst", vecs[6]);
        sort_and_drain("post_rst", vecs[6]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
